// File: rtl/time_adjust_ctrl.sv
// ---------------------------------------------------------------------------
// time_adjust_ctrl
//
// Sequencer and arbiter for a bank of five mod-N up/down counters
// (seconds, clock minutes, clock hours, alarm minutes, alarm hours).
// Turns the 1 Hz tick into carry-chained increments and routes the
// debounced up/down buttons to whichever counter the mode FSM selects.
//
// Optional feature: define AUTO_REPEAT_EN to enable button auto-repeat
// (first repeat after HOLD_CYCLES, then every REPEAT_CYCLES while held).
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   tick_1hz   in   one-cycle 1 Hz pulse (at least 4 cycles apart)
//   btn_mode   in   debounced mode button level
//   btn_up     in   debounced up button level
//   btn_down   in   debounced down button level
//   sec_count  in   current seconds value
//   min_count  in   current clock-minutes value
//   cnt_up     out  per-counter up enable   (0 sec, 1 clk min, 2 clk hr,
//                                             3 alm min, 4 alm hr)
//   cnt_down   out  per-counter down enable (same bit map)
//   cnt_load   out  per-counter load/clear  (same bit map)
//   mode       out  current state encoding
//   blink      out  display blink for the field being edited
// ---------------------------------------------------------------------------
module time_adjust_ctrl #(
   parameter int SEC_MOD       = 60,
   parameter int MIN_MOD       = 60,
   parameter int HR_MOD        = 24,
   parameter int TIMEOUT_TICKS = 30,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [5:0] sec_count,
   input  logic [5:0] min_count,
   output logic [4:0] cnt_up,
   output logic [4:0] cnt_down,
   output logic [4:0] cnt_load,
   output logic [2:0] mode,
   output logic       blink
);

   typedef enum logic [2:0] {
      RUN         = 3'd0,
      SET_CLK_HR  = 3'd1,
      SET_CLK_MIN = 3'd2,
      SET_ALM_HR  = 3'd3,
      SET_ALM_MIN = 3'd4
   } state_t;

   // Elaboration-time parameter sanity checks.
   if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255) begin : g_bad_timeout
      $error("time_adjust_ctrl: TIMEOUT_TICKS must be 1..255");
   end
   if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_repeat
      $error("time_adjust_ctrl: HOLD_CYCLES must be >= 2, REPEAT_CYCLES >= 1");
   end
   if (HR_MOD < 1 || HR_MOD > 64) begin : g_bad_hr
      $error("time_adjust_ctrl: HR_MOD out of range");
   end

   state_t     state, state_nxt;
   logic       mode_prev, up_prev, down_prev;
   logic       mode_edge, up_edge, down_edge, any_edge;
   logic [7:0] to_cnt, to_cnt_nxt;
   logic       blink_nxt;
   logic [4:0] up_nxt, down_nxt, load_nxt;
   logic       in_set, timekeep, bad_state;
   logic [4:0] sel_mask;
   logic       rpt_fire;   // auto-repeat pulse request this cycle
   logic       rpt_up;     // auto-repeat direction (1 = up)

   // Rising-edge detect on the debounced button levels.
   assign mode_edge = btn_mode & ~mode_prev;
   assign up_edge   = btn_up   & ~up_prev;
   assign down_edge = btn_down & ~down_prev;
   assign any_edge  = mode_edge | up_edge | down_edge;

   assign mode = state;

   // History resets to 1 so a button held through reset yields no edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_prev <= 1'b1;
         up_prev   <= 1'b1;
         down_prev <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         mode_prev <= btn_mode;
         up_prev   <= btn_up;
         down_prev <= btn_down;
      end
   end

`ifdef AUTO_REPEAT_EN
   // Auto-repeat tracker: armed by an accepted single up/down edge while the
   // opposite button is released; counts hold time, then repeat period.
   logic        rpt_armed, rpt_phase;
   logic [31:0] rpt_cnt;
   logic        rpt_held, rpt_other;
   logic [31:0] rpt_target;

   assign rpt_held   = rpt_up ? btn_up   : btn_down;
   assign rpt_other  = rpt_up ? btn_down : btn_up;
   // rpt_cnt is 1 the cycle after the edge, so HOLD_CYCLES-1 puts the first
   // repeat pulse HOLD_CYCLES after the edge; later pulses REPEAT_CYCLES apart.
   assign rpt_target = rpt_phase ? 32'(REPEAT_CYCLES) : 32'(HOLD_CYCLES - 1);
   assign rpt_fire   = rpt_armed && in_set && !mode_edge && rpt_held &&
                       !rpt_other && (rpt_cnt == rpt_target);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rpt_armed <= 1'b0;
         rpt_phase <= 1'b0;
         rpt_up    <= 1'b0;
         rpt_cnt   <= '0;
      end else if (!in_set || mode_edge) begin
         rpt_armed <= 1'b0;
         rpt_phase <= 1'b0;
         rpt_cnt   <= '0;
      end else if ((up_edge ^ down_edge) && !(up_edge ? btn_down : btn_up)) begin
         rpt_armed <= 1'b1;
         rpt_phase <= 1'b0;
         rpt_up    <= up_edge;
         rpt_cnt   <= 32'd1;
      end else if (rpt_armed) begin
         if (!rpt_held || rpt_other) begin
            rpt_armed <= 1'b0;
            rpt_phase <= 1'b0;
            rpt_cnt   <= '0;
         end else if (rpt_fire) begin
            rpt_phase <= 1'b1;
            rpt_cnt   <= 32'd1;
         end else begin
            rpt_cnt   <= rpt_cnt + 32'd1;
         end
      end
   end
`else
   assign rpt_fire = 1'b0;
   assign rpt_up   = 1'b0;
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves a signal unassigned, which would infer a latch.
      state_nxt  = state;
      to_cnt_nxt = to_cnt;
      blink_nxt  = blink;
      up_nxt     = '0;
      down_nxt   = '0;
      load_nxt   = '0;
      in_set     = 1'b0;
      timekeep   = 1'b0;
      bad_state  = 1'b0;
      sel_mask   = '0;

      case (state)
         RUN:         timekeep = 1'b1;
         SET_CLK_HR:  begin in_set = 1'b1; sel_mask = 5'b00100; end
         SET_CLK_MIN: begin in_set = 1'b1; sel_mask = 5'b00010; end
         SET_ALM_HR:  begin in_set = 1'b1; sel_mask = 5'b10000; timekeep = 1'b1; end
         SET_ALM_MIN: begin in_set = 1'b1; sel_mask = 5'b01000; timekeep = 1'b1; end
         default:     bad_state = 1'b1;
      endcase

      // Carry-chained timekeeping; counts are sampled in the tick cycle.
      if (timekeep && tick_1hz) begin
         up_nxt[0] = 1'b1;
         if (sec_count == 6'(SEC_MOD - 1)) begin
            up_nxt[1] = 1'b1;
            if (min_count == 6'(MIN_MOD - 1)) up_nxt[2] = 1'b1;
         end
      end

      // Button arbitration: mode wins; simultaneous up+down cancel out.
      if (in_set && !mode_edge && (up_edge ^ down_edge)) begin
         if (up_edge) up_nxt   = up_nxt   | sel_mask;
         else         down_nxt = down_nxt | sel_mask;
      end
      if (rpt_fire) begin
         if (rpt_up) up_nxt   = up_nxt   | sel_mask;
         else        down_nxt = down_nxt | sel_mask;
      end

      if (bad_state) begin
         state_nxt = RUN;
      end else if (mode_edge) begin
         case (state)
            RUN:         begin state_nxt = SET_CLK_HR; load_nxt[0] = 1'b1; end
            SET_CLK_HR:  state_nxt = SET_CLK_MIN;
            SET_CLK_MIN: state_nxt = SET_ALM_HR;
            SET_ALM_HR:  state_nxt = SET_ALM_MIN;
            default:     state_nxt = RUN;
         endcase
      end else if (in_set) begin
         if (any_edge || rpt_fire) begin
            to_cnt_nxt = '0;
         end else if (tick_1hz) begin
            // Timeout decided in the tick cycle so RUN appears alongside the
            // other tick-driven outputs, one cycle after the tick.
            if ({1'b0, to_cnt} + 9'd1 >= 9'(TIMEOUT_TICKS)) state_nxt = RUN;
            else                                             to_cnt_nxt = to_cnt + 8'd1;
         end
      end

      // Any state change restarts blink and the timeout; otherwise blink
      // toggles per tick while editing.
      if (state_nxt != state) begin
         blink_nxt  = 1'b0;
         to_cnt_nxt = '0;
      end else if (in_set && tick_1hz) begin
         blink_nxt  = ~blink;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         to_cnt   <= '0;
         blink    <= 1'b0;
         cnt_up   <= '0;
         cnt_down <= '0;
         cnt_load <= '0;
      end else begin
         state    <= state_nxt;
         to_cnt   <= to_cnt_nxt;
         blink    <= blink_nxt;
         cnt_up   <= up_nxt;
         cnt_down <= down_nxt;
         cnt_load <= load_nxt;
      end
   end

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_adjust_ctrl
//
// Scoreboard bench for time_adjust_ctrl. Inputs are driven on the falling
// edge; a behavioural model computes the registered outputs expected after
// the next rising edge and queues them. A monitor compares the DUT outputs
// against the queue shortly after each rising edge.
// ---------------------------------------------------------------------------
module tb_time_adjust_ctrl;

   localparam int SEC_MOD       = 60;
   localparam int MIN_MOD       = 60;
   localparam int HR_MOD        = 24;
   localparam int TIMEOUT_TICKS = 3;
   localparam int HOLD_CYCLES   = 1000000;
   localparam int REPEAT_CYCLES = 1000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick_1hz = 1'b0;
   logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [5:0] sec_count = '0, min_count = '0;
   logic [4:0] cnt_up, cnt_down, cnt_load;
   logic [2:0] mode;
   logic       blink;

   time_adjust_ctrl #(
      .SEC_MOD(SEC_MOD), .MIN_MOD(MIN_MOD), .HR_MOD(HR_MOD),
      .TIMEOUT_TICKS(TIMEOUT_TICKS), .HOLD_CYCLES(HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
      .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
      .sec_count(sec_count), .min_count(min_count),
      .cnt_up(cnt_up), .cnt_down(cnt_down), .cnt_load(cnt_load),
      .mode(mode), .blink(blink)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // Counter index edited in each mode (-1 = none).
   int   sel_bit [5] = '{-1, 2, 1, 4, 3};
   int   m_mode, m_to;
   bit   m_blink, pm, pu, pd;
   logic [18:0] exp_q [$];   // {up, down, load, mode, blink}

   task automatic model_reset();
      m_mode = 0; m_to = 0; m_blink = 0;
      pm = 1; pu = 1; pd = 1;
   endtask

   task automatic model_step(input bit tk, input bit bm, input bit bu, input bit bd,
                             input int sec, input int mn, output logic [18:0] e);
      bit me, ue, de;
      int nxt;
      logic [4:0] up, dn, ld;
      me = bm && !pm; ue = bu && !pu; de = bd && !pd;
      pm = bm; pu = bu; pd = bd;
      up = '0; dn = '0; ld = '0;
      if ((m_mode == 0 || m_mode == 3 || m_mode == 4) && tk) begin
         up[0] = 1'b1;
         if (sec == SEC_MOD - 1) begin
            up[1] = 1'b1;
            if (mn == MIN_MOD - 1) up[2] = 1'b1;
         end
      end
      if (m_mode != 0 && !me && (ue != de)) begin
         if (ue) up[sel_bit[m_mode]] = 1'b1;
         else    dn[sel_bit[m_mode]] = 1'b1;
      end
      nxt = m_mode;
      if (me) begin
         nxt = (m_mode + 1) % 5;
         if (m_mode == 0) ld[0] = 1'b1;
      end else if (m_mode != 0) begin
         if (ue || de) m_to = 0;
         else if (tk) begin
            m_to++;
            if (m_to >= TIMEOUT_TICKS) nxt = 0;
         end
      end
      if (nxt != m_mode) begin
         m_blink = 0;
         m_to = 0;
      end else if (m_mode != 0 && tk) begin
         m_blink = !m_blink;
      end
      m_mode = nxt;
      e = {up, dn, ld, 3'(m_mode), m_blink};
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic apply(input bit tk, input bit bm, input bit bu, input bit bd,
                        input int sec, input int mn);
      logic [18:0] e;
      tick_1hz = tk; btn_mode = bm; btn_up = bu; btn_down = bd;
      sec_count = 6'(sec); min_count = 6'(mn);
      model_step(tk, bm, bu, bd, sec, mn, e);
      exp_q.push_back(e);
   endtask

   task automatic cyc(input bit tk, input bit bm, input bit bu, input bit bd,
                      input int sec, input int mn);
      @(negedge clk);
      apply(tk, bm, bu, bd, sec, mn);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic press_mode();
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
   endtask

   // Reset with the given button levels held; outputs must be zero throughout.
   task automatic do_reset(input bit bm, input bit bu, input bit bd);
      @(negedge clk);
      reset = 1'b1; tick_1hz = 1'b0;
      btn_mode = bm; btn_up = bu; btn_down = bd;
      repeat (3) @(negedge clk);
      check("reset_outputs", {cnt_up, cnt_down, cnt_load, mode, blink}, 32'd0);
      model_reset();
      reset = 1'b0;
      apply(0, bm, bu, bd, 0, 0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [18:0] e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {cnt_up, cnt_down, cnt_load, mode, blink};
            check("outputs{up,down,load,mode,blink}", 32'(a), 32'(e));
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int since_tick;
      bit bm, bu, bd, tk;
      int sec, mn, r;

      // Reset with up held: releasing reset must not produce an up pulse.
      do_reset(0, 1, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      idle(2);

      // Full carry chain in RUN.
      cyc(1, 0, 0, 0, 59, 59);
      idle(4);
      cyc(1, 0, 0, 0, 59, 10);
      idle(4);
      cyc(1, 0, 0, 0, 0, 59);
      idle(4);

      // Enter SET_CLK_HR: load seconds, tick ignored, up/down route to hours.
      press_mode();
      cyc(1, 0, 0, 0, 59, 59);
      idle(3);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      // Advance to SET_ALM_MIN; up edge coincident with tick, then up+down.
      press_mode(); press_mode(); press_mode();
      idle(2);
      cyc(1, 0, 1, 0, 10, 0);
      idle(4);
      cyc(0, 0, 1, 1, 0, 0);
      idle(2);
      // Mode edge coincident with up: mode wins.
      cyc(0, 1, 1, 0, 0, 0);
      idle(2);

      // Timeout from SET_CLK_MIN after TIMEOUT_TICKS ticks.
      press_mode(); press_mode();
      for (int i = 0; i < TIMEOUT_TICKS; i++) begin
         cyc(1, 0, 0, 0, 5, 5);
         idle(4);
      end
      idle(2);

      // Randomised phase with a mid-run reset.
      bm = 0; bu = 0; bd = 0; since_tick = 10;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset(bm, bu, bd);
            since_tick = 10;
         end
         tk = (since_tick >= 4) && ($urandom_range(0, 2) == 0);
         since_tick = tk ? 1 : since_tick + 1;
         if ($urandom_range(0, 7) == 0) bm = !bm;
         if ($urandom_range(0, 3) == 0) bu = !bu;
         if ($urandom_range(0, 3) == 0) bd = !bd;
         r   = $urandom_range(0, 3);
         sec = (r < 2) ? SEC_MOD - 1 : (r == 2 ? 0 : int'($urandom_range(0, 59)));
         mn  = ($urandom_range(0, 1) == 0) ? MIN_MOD - 1 : int'($urandom_range(0, 59));
         cyc(tk, bm, bu, bd, sec, mn);
      end
      idle(2);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
